// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, false-start rejection
// and break hold. One byte plus a one-cycle w_flag per correctly framed character.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       w_flag,
    output logic       busy,
    output logic       frame_err
);

    localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_HOLD
    } state_t;

    state_t      state;
    logic        rx_meta;
    logic        rx_s;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    // Flops preset to 1 so reset looks like an idle line, not a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_out  <= '0;
            w_flag    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            w_flag    <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt       <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_cnt == BIT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            byte_out <= shreg;
                            w_flag   <= 1'b1;
                            state    <= IDLE;
                            busy     <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK_HOLD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                // A held-low line must not be re-decoded as a stream of 8'h00 frames.
                BREAK_HOLD: begin
                    baud_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed frames at 16 clk/bit plus a
// skewed-baud random sweep at 4, 17 and 868 clk/bit against a byte-queue model.
`timescale 1ns/1ps
module tb_uart_rx_byte;

    logic clk;
    logic rst_n;
    logic rx16, rx4, rx17, rx868;
    logic [7:0] b16, b4, b17, b868;
    logic w16, w4, w17, w868;
    logic busy16, busy4, busy17, busy868;
    logic fe16, fe4, fe17, fe868;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    longint cyc = 0;

    logic [7:0] q16[$], q4[$], q17[$], q868[$];
    logic [7:0] exp4[$], exp17[$], exp868[$];
    longint     t16[$];
    int unsigned err16 = 0, err4 = 0, err17 = 0, err868 = 0, both_cnt = 0;

    uart_rx_byte #(.CLKS_PER_BIT(16)) u16 (
        .clk(clk), .rst_n(rst_n), .rx(rx16), .byte_out(b16),
        .w_flag(w16), .busy(busy16), .frame_err(fe16));
    uart_rx_byte #(.CLKS_PER_BIT(4)) u4 (
        .clk(clk), .rst_n(rst_n), .rx(rx4), .byte_out(b4),
        .w_flag(w4), .busy(busy4), .frame_err(fe4));
    uart_rx_byte #(.CLKS_PER_BIT(17)) u17 (
        .clk(clk), .rst_n(rst_n), .rx(rx17), .byte_out(b17),
        .w_flag(w17), .busy(busy17), .frame_err(fe17));
    uart_rx_byte #(.CLKS_PER_BIT(868)) u868 (
        .clk(clk), .rst_n(rst_n), .rx(rx868), .byte_out(b868),
        .w_flag(w868), .busy(busy868), .frame_err(fe868));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (w16) begin
            q16.push_back(b16);
            t16.push_back(cyc);
        end
        if (w4)   q4.push_back(b4);
        if (w17)  q17.push_back(b17);
        if (w868) q868.push_back(b868);
        if (fe16)  err16++;
        if (fe4)   err4++;
        if (fe17)  err17++;
        if (fe868) err868++;
        if ((w16 && fe16) || (w4 && fe4) || (w17 && fe17) || (w868 && fe868)) both_cnt++;
    end

    task automatic check(input string tag, input longint obs, input longint expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int unsigned which, input logic v);
        case (which)
            0:       rx16  = v;
            1:       rx4   = v;
            2:       rx17  = v;
            default: rx868 = v;
        endcase
    endtask

    task automatic send_frame(input int unsigned which, input logic [7:0] b,
                              input logic stop_val, input realtime bit_ns);
        drive(which, 1'b0);
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            drive(which, b[i]);
            #(bit_ns);
        end
        drive(which, stop_val);
        #(bit_ns);
    endtask

    // Every correctly framed character must come out, in order; skew alternates randomly.
    task automatic sweep(input int unsigned which, input int unsigned cpb,
                         input int unsigned count, input bit exhaustive);
        logic [7:0] b;
        realtime    bit_ns;
        for (int k = 0; k < int'(count); k++) begin
            b = exhaustive ? 8'(k) : 8'($urandom);
            bit_ns = real'(cpb) * 10.0 * (($urandom_range(0, 1) == 1) ? 1.02 : 0.98);
            @(negedge clk);
            send_frame(which, b, 1'b1, bit_ns);
            case (which)
                1:       exp4.push_back(b);
                2:       exp17.push_back(b);
                default: exp868.push_back(b);
            endcase
        end
        #(real'(cpb) * 30.0);
    endtask

    task automatic cmp_q(input string tag, input logic [7:0] got[$], input logic [7:0] expq[$]);
        int unsigned mism;
        mism = 0;
        check({tag, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            if (got[i] !== expq[i]) mism++;
        check({tag, "_data"}, mism, 0);
    endtask

    initial begin
        int unsigned base;
        int unsigned ebase;
        rst_n = 1'b0;
        rx16 = 1'b1; rx4 = 1'b1; rx17 = 1'b1; rx868 = 1'b1;
        #20;
        check("reset_byte_out", b16, 8'h00);
        check("reset_w_flag", w16, 0);
        check("reset_busy", busy16, 0);
        check("reset_frame_err", fe16, 0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // Single frame 0x41
        base = q16.size();
        fork
            send_frame(0, 8'h41, 1'b1, 160.0);
            begin
                #480;
                check("busy_mid_frame", busy16, 1);
            end
        join
        #320;
        check("t1_pulses", q16.size() - base, 1);
        if (q16.size() > base) check("t1_byte_in_pulse", q16[base], 8'h41);
        check("t1_byte_held", b16, 8'h41);
        check("t1_busy_after", busy16, 0);

        // Back-to-back 0x12, 0x34
        base = q16.size();
        ebase = err16;
        send_frame(0, 8'h12, 1'b1, 160.0);
        send_frame(0, 8'h34, 1'b1, 160.0);
        #320;
        check("t2_pulses", q16.size() - base, 2);
        if (q16.size() >= base + 2) begin
            check("t2_first", q16[base], 8'h12);
            check("t2_second", q16[base+1], 8'h34);
            check("t2_spacing", t16[base+1] - t16[base], 160);
        end
        check("t2_no_frame_err", err16 - ebase, 0);

        // 5-clk low glitch
        base = q16.size();
        ebase = err16;
        rx16 = 1'b0;
        #50;
        rx16 = 1'b1;
        #320;
        check("t3_no_w_flag", q16.size() - base, 0);
        check("t3_no_frame_err", err16 - ebase, 0);
        check("t3_byte_kept", b16, 8'h34);
        check("t3_idle", busy16, 0);

        // Bad stop bit followed by a 40-bit break
        base = q16.size();
        ebase = err16;
        send_frame(0, 8'hA5, 1'b0, 160.0);
        #(40 * 160);
        check("t4_busy_in_break", busy16, 1);
        check("t4_one_frame_err", err16 - ebase, 1);
        check("t4_no_w_flag", q16.size() - base, 0);
        check("t4_byte_kept", b16, 8'h34);
        rx16 = 1'b1;
        #320;
        check("t4_idle_after_release", busy16, 0);
        send_frame(0, 8'h5A, 1'b1, 160.0);
        #320;
        check("t4_recover_pulses", q16.size() - base, 1);
        check("t4_recover_byte", b16, 8'h5A);
        check("t4_frame_err_total", err16 - ebase, 1);

        // Reset during data bit 4 of 0xFF
        base = q16.size();
        fork
            send_frame(0, 8'hFF, 1'b1, 160.0);
            begin
                #(160 * 5 + 80);
                rst_n = 1'b0;
                #20;
                check("t5_byte_in_reset", b16, 8'h00);
                check("t5_busy_in_reset", busy16, 0);
                rst_n = 1'b1;
            end
        join
        #320;
        check("t5_aborted_no_w_flag", q16.size() - base, 0);
        check("t5_byte_after_reset", b16, 8'h00);
        send_frame(0, 8'h0F, 1'b1, 160.0);
        #320;
        check("t5_pulses", q16.size() - base, 1);
        if (q16.size() > base) check("t5_byte", q16[base], 8'h0F);
        check("t5_byte_held", b16, 8'h0F);

        // Skewed-baud sweep across three bit periods in parallel
        fork
            sweep(1, 4, 256, 1'b1);
            sweep(2, 17, 64, 1'b0);
            sweep(3, 868, 4, 1'b0);
        join
        cmp_q("sweep4", q4, exp4);
        cmp_q("sweep17", q17, exp17);
        cmp_q("sweep868", q868, exp868);
        check("sweep4_frame_err", err4, 0);
        check("sweep17_frame_err", err17, 0);
        check("sweep868_frame_err", err868, 0);
        check("w_flag_and_frame_err_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
